// File: rtl/timer_cmp.sv
// timer_cmp: prescaled up-counter with compare channels, overflow/compare
// status, level interrupt and a small word-addressed register bank.
module timer_cmp #(
    parameter int DATA_W       = 32,
    parameter int PRESCALE_W   = 16,
    parameter int PRESCALE_RST = 999,
    parameter int NUM_CMP      = 2
) (
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic              req_in,
    input  logic              we_in,
    input  logic [7:0]        addr_in,
    input  logic [DATA_W-1:0] wdata_in,
    output logic [DATA_W-1:0] rdata_out,
    output logic              ack_out,
    output logic [DATA_W-1:0] time_clk_out,
    output logic              irq_out
);

    localparam logic [5:0] W_CTRL     = 6'h00;
    localparam logic [5:0] W_PRESCALE = 6'h01;
    localparam logic [5:0] W_COUNT    = 6'h02;
    localparam logic [5:0] W_STATUS   = 6'h03;
    localparam logic [5:0] W_IRQ_EN   = 6'h04;
    localparam logic [5:0] W_CMP_BASE = 6'h08;

    logic [1:0]            ctrl;
    logic [PRESCALE_W-1:0] prescale;
    logic [PRESCALE_W-1:0] psc_cnt;
    logic [DATA_W-1:0]     count;
    logic [DATA_W-1:0]     cmp [NUM_CMP];
    logic [NUM_CMP:0]      status;
    logic [NUM_CMP:0]      irq_en;

    logic [5:0]            word;
    logic                  wr;
    logic                  wr_ctrl;
    logic                  wr_prescale;
    logic                  wr_count;
    logic                  wr_status;
    logic                  wr_irq_en;
    logic [NUM_CMP-1:0]    wr_cmp;
    logic                  tick;
    logic                  cnt_adv;
    logic                  ovf_hit;
    logic [DATA_W-1:0]     count_tick;
    logic [NUM_CMP:0]      hw_set;
    logic [DATA_W-1:0]     rd_mux;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^addr_in[1:0];

    // Address decode; only word offsets matter.
    always_comb begin
        word        = addr_in[7:2];
        wr          = req_in && we_in;
        wr_ctrl     = wr && (word == W_CTRL);
        wr_prescale = wr && (word == W_PRESCALE);
        wr_count    = wr && (word == W_COUNT);
        wr_status   = wr && (word == W_STATUS);
        wr_irq_en   = wr && (word == W_IRQ_EN);
        wr_cmp      = '0;
        for (int i = 0; i < NUM_CMP; i++) begin
            wr_cmp[i] = wr && (word == W_CMP_BASE + 6'(i));
        end
    end

    assign tick = ctrl[0] && (psc_cnt == prescale);

    // Value the counter would take on a tick, plus overflow detection.
    always_comb begin
        ovf_hit    = 1'b0;
        count_tick = count + DATA_W'(1);
        if (ctrl[1] && (count == cmp[0])) begin
            count_tick = '0;
        end else if (count == {DATA_W{1'b1}}) begin
            count_tick = '0;
            ovf_hit    = 1'b1;
        end
    end

    // A COUNT write in a tick cycle swallows the tick; compares use the
    // CMP values held before any same-cycle CMP write.
    always_comb begin
        cnt_adv   = tick && !wr_count;
        hw_set    = '0;
        hw_set[0] = cnt_adv && ovf_hit;
        for (int i = 0; i < NUM_CMP; i++) begin
            hw_set[i+1] = cnt_adv && (count_tick == cmp[i]);
        end
    end

    // Prescaler: wraps at PRESCALE, restarts on any PRESCALE or COUNT write.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            psc_cnt <= '0;
        end else if (wr_prescale || wr_count) begin
            psc_cnt <= '0;
        end else if (ctrl[0]) begin
            psc_cnt <= tick ? '0 : psc_cnt + PRESCALE_W'(1);
        end
    end

    // Control, counter, compare and status registers.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            ctrl     <= '0;
            prescale <= PRESCALE_W'(PRESCALE_RST);
            count    <= '0;
            status   <= '0;
            irq_en   <= '0;
            for (int i = 0; i < NUM_CMP; i++) begin
                cmp[i] <= {DATA_W{1'b1}};
            end
        end else begin
            if (wr_ctrl) begin
                ctrl <= wdata_in[1:0];
            end
            if (wr_prescale) begin
                prescale <= wdata_in[PRESCALE_W-1:0];
            end
            if (wr_count) begin
                count <= wdata_in;
            end else if (tick) begin
                count <= count_tick;
            end
            if (wr_irq_en) begin
                irq_en <= wdata_in[NUM_CMP:0];
            end
            // Hardware set wins over a same-cycle write-1-to-clear.
            status <= (wr_status ? (status & ~wdata_in[NUM_CMP:0]) : status) | hw_set;
            for (int i = 0; i < NUM_CMP; i++) begin
                if (wr_cmp[i]) begin
                    cmp[i] <= wdata_in;
                end
            end
        end
    end

    // Read multiplexer; narrow registers zero-extended, unmapped reads 0.
    always_comb begin
        rd_mux = '0;
        case (word)
            W_CTRL:     rd_mux[1:0]            = ctrl;
            W_PRESCALE: rd_mux[PRESCALE_W-1:0] = prescale;
            W_COUNT:    rd_mux                 = count;
            W_STATUS:   rd_mux[NUM_CMP:0]      = status;
            W_IRQ_EN:   rd_mux[NUM_CMP:0]      = irq_en;
            default: begin
                for (int i = 0; i < NUM_CMP; i++) begin
                    if (word == W_CMP_BASE + 6'(i)) begin
                        rd_mux = cmp[i];
                    end
                end
            end
        endcase
    end

    // Bus response: one-cycle ack, registered read data.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            ack_out   <= 1'b0;
            rdata_out <= '0;
        end else begin
            ack_out   <= req_in;
            rdata_out <= (req_in && !we_in) ? rd_mux : '0;
        end
    end

    assign time_clk_out = count;
    assign irq_out      = |(status & irq_en);

endmodule
